// File: rtl/vga_fb_pkg.sv
// Shared types and VGA timing constants for the framebuffer scheduler and vga_send_image.
package vga_fb_pkg;

    typedef logic [11:0] pixel_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } fb_state_e;

    // Default 640x480@60 timing, shared with vga_send_image
    localparam int VGA_ACTIVE_HORI  = 640;
    localparam int VGA_ACTIVE_VERT  = 480;
    localparam int VGA_HORI_TOTAL   = 800;
    localparam int VGA_VERT_TOTAL   = 525;
    localparam int VGA_SCALE_SHIFT  = 2;
    localparam int VGA_PERIOD_COUNT = 4;
    localparam int VGA_FB_ADDR_W    = 15;
    localparam int VGA_CNT_W        = 10;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Lookahead address generator: maps the current scan position to the framebuffer
// word needed for the next displayed pixel, and flags whether that pixel is visible.
module vga_fb_addr_gen
    import vga_fb_pkg::*;
#(
    parameter int ACTIVE_HORI = VGA_ACTIVE_HORI,
    parameter int ACTIVE_VERT = VGA_ACTIVE_VERT,
    parameter int HORI_TOTAL  = VGA_HORI_TOTAL,
    parameter int VERT_TOTAL  = VGA_VERT_TOTAL,
    parameter int SCALE_SHIFT = VGA_SCALE_SHIFT,
    parameter int ADDR_W      = VGA_FB_ADDR_W
) (
    input  logic [VGA_CNT_W-1:0] h_count,
    input  logic [VGA_CNT_W-1:0] v_count,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic                 rd_needed
);

    localparam int                   FB_W     = ACTIVE_HORI >> SCALE_SHIFT;
    localparam logic [ADDR_W-1:0]    FB_W_A   = ADDR_W'(FB_W);
    localparam logic [VGA_CNT_W-1:0] H_LAST   = VGA_CNT_W'(HORI_TOTAL - 1);
    localparam logic [VGA_CNT_W-1:0] V_LAST   = VGA_CNT_W'(VERT_TOTAL - 1);
    localparam logic [VGA_CNT_W-1:0] H_ACTIVE = VGA_CNT_W'(ACTIVE_HORI);
    localparam logic [VGA_CNT_W-1:0] V_ACTIVE = VGA_CNT_W'(ACTIVE_VERT);

    logic [VGA_CNT_W-1:0] nh;
    logic [VGA_CNT_W-1:0] nv;
    logic [ADDR_W-1:0]    fb_row;
    logic [ADDR_W-1:0]    fb_col;

    // Next scan position, wrapping at end of line and end of frame
    always_comb begin
        nh = h_count + 1'b1;
        nv = v_count;
        if (h_count == H_LAST) begin
            nh = '0;
            nv = (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end
    end

    // Scaled framebuffer coordinates and linear word address
    always_comb begin
        fb_row    = ADDR_W'(nv >> SCALE_SHIFT);
        fb_col    = ADDR_W'(nh >> SCALE_SHIFT);
        rd_addr   = fb_row * FB_W_A + fb_col;
        rd_needed = (nh < H_ACTIVE) && (nv < V_ACTIVE);
    end

endmodule

// File: rtl/vga_fb_scheduler.sv
// Single-port framebuffer scheduler: the VGA lookahead read owns every enable
// cycle, the loader write stream gets all other cycles while in LOAD.
// Build option: define FB_VBLANK_WR_EN to restrict writes to vertical blanking.
module vga_fb_scheduler
    import vga_fb_pkg::*;
#(
    parameter int ACTIVE_HORI  = VGA_ACTIVE_HORI,
    parameter int ACTIVE_VERT  = VGA_ACTIVE_VERT,
    parameter int HORI_TOTAL   = VGA_HORI_TOTAL,
    parameter int VERT_TOTAL   = VGA_VERT_TOTAL,
    parameter int SCALE_SHIFT  = VGA_SCALE_SHIFT,
    parameter int PERIOD_COUNT = VGA_PERIOD_COUNT,
    parameter int ADDR_W       = VGA_FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              frame_start,
    input  logic              wr_valid,
    input  logic [11:0]       wr_data,
    output logic              wr_ready,
    output logic              loading,
    output logic              frame_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [11:0]       ram_wdata,
    input  logic [11:0]       ram_rdata,
    output logic [11:0]       rgb_colour
);

    localparam int                FB_W     = ACTIVE_HORI >> SCALE_SHIFT;
    localparam int                FB_H     = ACTIVE_VERT >> SCALE_SHIFT;
    localparam int                FB_DEPTH = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(FB_DEPTH - 1);

    // The read result must be registered before the next pixel tick
    if (PERIOD_COUNT < 3) begin : g_bad_period
        $error("vga_fb_scheduler: PERIOD_COUNT must be >= 3");
    end
    if (FB_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("vga_fb_scheduler: framebuffer does not fit in ADDR_W");
    end

    fb_state_e         state;
    fb_state_e         state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              done_next;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_needed;
    logic              rd_pending;
    logic              wr_fire;
    logic              wr_window;

    vga_fb_addr_gen #(
        .ACTIVE_HORI (ACTIVE_HORI),
        .ACTIVE_VERT (ACTIVE_VERT),
        .HORI_TOTAL  (HORI_TOTAL),
        .VERT_TOTAL  (VERT_TOTAL),
        .SCALE_SHIFT (SCALE_SHIFT),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .h_count   (h_count),
        .v_count   (v_count),
        .rd_addr   (rd_addr),
        .rd_needed (rd_needed)
    );

`ifdef FB_VBLANK_WR_EN
    // Tear-free mode: only write while the beam is in vertical blanking
    always_comb wr_window = (v_count >= 10'(ACTIVE_VERT));
`else
    always_comb wr_window = 1'b1;
`endif

    // Write handshake: any non-tick cycle of LOAD is a write slot
    always_comb begin
        wr_ready = !rst && !enable && (state == LOAD) && wr_window;
        wr_fire  = wr_valid && wr_ready;
        loading  = (state == LOAD);
    end

    // RAM port mux: reader has priority, writes only when handshake fires
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = wr_data;
        if (!rst) begin
            if (enable && rd_needed) begin
                ram_en   = 1'b1;
                ram_addr = rd_addr;
            end else if (wr_fire) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = wr_ptr;
            end
        end
    end

    // Load FSM next state; frame_start overrides a same-cycle write's pointer update
    always_comb begin
        state_next = state;
        ptr_next   = wr_ptr;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                end
            end
            LOAD: begin
                if (frame_start) begin
                    ptr_next = '0;
                end else if (wr_fire) begin
                    if (wr_ptr == PTR_LAST) begin
                        ptr_next   = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ptr_next = wr_ptr + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // FSM state, write pointer and completion pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ptr     <= ptr_next;
            frame_done <= done_next;
        end
    end

    // Read pipeline: issue on tick, RAM answers next cycle, colour registered after that
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rgb_colour <= '0;
        end else begin
            rd_pending <= enable && rd_needed;
            if (rd_pending) begin
                rgb_colour <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Self-checking bench for vga_fb_scheduler: directed lookahead reads plus a
// write scoreboard (expected address/data queued on drive, popped on RAM write).
// Honours FB_VBLANK_WR_EN when the design is built with it.
module tb_vga_fb_scheduler;

    localparam int ADDR_W   = 15;
    localparam int FB_DEPTH = 160 * 120;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable;
    logic [9:0]        h_count = 10'd700;
    logic [9:0]        v_count = 10'd500;
    logic              frame_start = 1'b0;
    logic              wr_valid = 1'b0;
    logic [11:0]       wr_data = '0;
    logic              wr_ready;
    logic              loading;
    logic              frame_done;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [11:0]       ram_wdata;
    logic [11:0]       ram_rdata = '0;
    logic [11:0]       rgb_colour;

    logic       man_en = 1'b0;
    logic       auto_en = 1'b0;
    logic [1:0] div = '0;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ptr = 0;
    logic exp_load = 1'b0;
    int wr_count = 0;
    int done_count = 0;
    logic [ADDR_W+11:0] exp_q[$];

    assign enable = man_en | (auto_en & (div == 2'd0));

    vga_fb_scheduler #(
        .ACTIVE_HORI  (640),
        .ACTIVE_VERT  (480),
        .HORI_TOTAL   (800),
        .VERT_TOTAL   (525),
        .SCALE_SHIFT  (2),
        .PERIOD_COUNT (4),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .h_count     (h_count),
        .v_count     (v_count),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .loading     (loading),
        .frame_done  (frame_done),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .rgb_colour  (rgb_colour)
    );

    always #5 clk = ~clk;

    // Pixel tick divider for the auto-enable mode
    initial begin
        forever begin
            @(posedge clk);
            #1 div = div + 2'd1;
        end
    end

    // Read-only RAM model with fixed contents; 1-cycle read latency
    function automatic logic [11:0] pat(input logic [ADDR_W-1:0] a);
        return (a == 15'd2) ? 12'hABC : (12'(a) ^ 12'h5A5);
    endfunction

    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= pat(ram_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ready();
        logic win;
`ifdef FB_VBLANK_WR_EN
        win = (v_count >= 10'd480);
`else
        win = 1'b1;
`endif
        return exp_load && !enable && win && !rst;
    endfunction

    // Write scoreboard monitor and frame_done counter
    always @(negedge clk) begin
        logic [ADDR_W+11:0] e;
        if (ram_en && ram_we) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {17'd0, ram_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {17'd0, ram_addr}, {17'd0, e[ADDR_W+11:12]});
                check("wr_data", {20'd0, ram_wdata}, {20'd0, e[11:0]});
            end
        end
        if (frame_done) done_count++;
    end

    task automatic do_read(input logic [9:0] h, input logic [9:0] v, input logic exp_en,
                           input logic [ADDR_W-1:0] exp_addr, input logic [11:0] exp_rgb);
        @(posedge clk);
        #1 h_count = h; v_count = v; man_en = 1'b1;
        @(negedge clk);
        check("rd_en", {31'd0, ram_en}, {31'd0, exp_en});
        check("rd_we", {31'd0, ram_we}, 32'd0);
        if (exp_en) check("rd_addr", {17'd0, ram_addr}, {17'd0, exp_addr});
        @(posedge clk);
        #1 man_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rgb", {20'd0, rgb_colour}, {20'd0, exp_rgb});
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        exp_load = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            logic [11:0] d;
            logic        acc;
            int          budget;
            d = 12'($urandom);
            wr_valid = 1'b1;
            wr_data = d;
            exp_q.push_back({ADDR_W'(exp_ptr), d});
            acc = 1'b0;
            budget = 0;
            while (!acc) begin
                @(negedge clk);
                check("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready()});
                acc = wr_ready;
                if (acc) begin
                    exp_ptr++;
                    if (exp_ptr == FB_DEPTH) begin
                        exp_ptr = 0;
                        exp_load = 1'b0;
                    end
                end
                @(posedge clk);
                #1;
                budget++;
                if (!acc && budget > 20) begin
                    check("wr_timeout", 32'd0, 32'd1);
                    wr_valid = 1'b0;
                    return;
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    // Offer a pixel for n cycles where none should be accepted
    task automatic idle_check(input int n);
        wr_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", {31'd0, wr_ready}, {31'd0, exp_ready()});
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        #50000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rgb", {20'd0, rgb_colour}, 32'd0);
        check("rst_loading", {31'd0, loading}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);

        // Lookahead reads
        do_read(10'd7,   10'd0,   1'b1, 15'd2,   12'hABC);
        do_read(10'd799, 10'd4,   1'b1, 15'd160, 12'h505);
        do_read(10'd799, 10'd524, 1'b1, 15'd0,   12'h5A5);
        do_read(10'd639, 10'd10,  1'b0, 15'd0,   12'h5A5);

        // Writes held across pixel ticks
        h_count = 10'd700; v_count = 10'd500;
        auto_en = 1'b1;
        idle_check(3);
        start_frame();
        send_pixels(5);
        send_pixels(95);

        // Reset mid-load, with a read and a write both requested
        @(posedge clk);
        #1 rst = 1'b1; wr_valid = 1'b1; man_en = 1'b1; h_count = 10'd7; v_count = 10'd0;
        @(negedge clk);
        check("rstmid_ram_en", {31'd0, ram_en}, 32'd0);
        check("rstmid_wr_ready", {31'd0, wr_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; wr_valid = 1'b0; man_en = 1'b0; h_count = 10'd700; v_count = 10'd500;
        exp_load = 1'b0; exp_ptr = 0;
        @(negedge clk);
        check("rstmid_loading", {31'd0, loading}, 32'd0);
        idle_check(3);
        start_frame();
        send_pixels(3);
        check("done_none", done_count, 32'd0);

`ifdef FB_VBLANK_WR_EN
        v_count = 10'd100;
        start_frame();
        idle_check(6);
        v_count = 10'd480;
        send_pixels(4);
        v_count = 10'd500;
`endif

        // Full frame, restarted from within LOAD
        start_frame();
        wr_count = 0;
        send_pixels(FB_DEPTH);
        @(negedge clk);
        check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        @(posedge clk);
        #1;
        idle_check(4);
        check("done_count", done_count, 32'd1);
        check("frame_loading", {31'd0, loading}, 32'd0);
        check("frame_wr_count", wr_count, FB_DEPTH);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
